aes_periph_arbiter: RTL

Round-robin arbiter that shares the single peripheral (register-file) slave port of the AES engine between `N_REQ` independent requesters, e.g. several cluster cores programming jobs. It sits between the cores' peripheral masters and the engine's `periph` slave. It forwards one request at a time and holds the selection while the engine stalls. It records each granted requester in a small in-order queue so that every response is routed back to the requester that issued it.

---
 rtl/aes_package.sv | 9 +
 rtl/aes_arb_resp_fifo.sv | 60 ++++++
 rtl/aes_periph_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_package.sv
// Shared definitions for the AES engine peripheral-port arbiter.
package aes_package;

    localparam int AES_ARB_QDEPTH  = 2;
    localparam int AES_ARB_MAX_REQ = 8;

    typedef logic [$clog2(AES_ARB_MAX_REQ)-1:0] aes_arb_idx_t;

endpackage

// File: rtl/aes_arb_resp_fifo.sv
// In-order queue of granted requester indices awaiting a response.
module aes_arb_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    do_push;
    logic                    do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_periph_arbiter.sv
// Round-robin arbiter sharing the AES engine periph slave between N_REQ
// masters, with in-order response routing.
module aes_periph_arbiter
    import aes_package::*;
#(
    parameter int N_REQ = 4,
    parameter int ID    = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            in_req,
    output logic [N_REQ-1:0]            in_gnt,
    input  logic [N_REQ-1:0][31:0]      in_add,
    input  logic [N_REQ-1:0]            in_wen,
    input  logic [N_REQ-1:0][3:0]       in_be,
    input  logic [N_REQ-1:0][31:0]      in_data,
    input  logic [N_REQ-1:0][ID-1:0]    in_id,
    output logic [N_REQ-1:0][31:0]      in_r_data,
    output logic [N_REQ-1:0]            in_r_valid,
    output logic [N_REQ-1:0][ID-1:0]    in_r_id,
    output logic                        out_req,
    output logic [31:0]                 out_add,
    output logic                        out_wen,
    output logic [3:0]                  out_be,
    output logic [31:0]                 out_data,
    output logic [ID-1:0]               out_id,
    input  logic                        out_gnt,
    input  logic [31:0]                 out_r_data,
    input  logic                        out_r_valid,
    input  logic [ID-1:0]               out_r_id,
    output logic                        err_o
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_idx;
    logic          locked;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          found;
    logic          lock_hold;
    logic          active;
    logic          handshake;
    logic          q_full;
    logic          q_empty;
    logic          q_pop;
    logic [IW-1:0] q_head;

    // A lock only holds while its owner keeps requesting.
    always_comb begin
        lock_hold = locked & in_req[lock_idx];
        found     = 1'b0;
        cand      = '0;
        winner    = lock_idx;
        if (!lock_hold) begin
            winner = '0;
            for (int k = 0; k < N_REQ; k++) begin
                cand = IW'((int'(rr_ptr) + k) % N_REQ);
                if (!found && in_req[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    assign active    = (|in_req) & ~rst_i;
    assign out_req   = active & ~q_full;
    assign handshake = out_req & out_gnt;
    assign q_pop     = out_r_valid & ~q_empty;

    always_comb begin
        out_add  = '0;
        out_wen  = 1'b0;
        out_be   = '0;
        out_data = '0;
        out_id   = '0;
        in_gnt   = '0;
        if (active) begin
            out_add  = in_add[winner];
            out_wen  = in_wen[winner];
            out_be   = in_be[winner];
            out_data = in_data[winner];
            out_id   = in_id[winner];
        end
        if (handshake) begin
            in_gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        in_r_valid = '0;
        if (q_pop) begin
            in_r_valid[q_head] = 1'b1;
        end
    end

    assign in_r_data = {N_REQ{out_r_data}};
    assign in_r_id   = {N_REQ{out_r_id}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            err_o    <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                locked <= 1'b0;
            end else if (out_req) begin
                locked   <= 1'b1;
                lock_idx <= winner;
            end else if (locked && !in_req[lock_idx]) begin
                locked <= 1'b0;
            end
            if (out_r_valid && q_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    aes_arb_resp_fifo #(
        .DEPTH (AES_ARB_QDEPTH),
        .W     (IW)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (handshake),
        .push_data (winner),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

endmodule
